// File: rtl/prog_loader.sv
// prog_loader: writer side of the instruction memory.
// Takes a length-prefixed byte stream from a host (valid/ready), packs byte
// pairs into 9-bit instructions, writes them to consecutive addresses and
// keeps the CPU in reset until a complete, well-formed program is loaded.
// Optional checksum stage: define LOADER_CSUM_EN to require a trailing
// mod-256 checksum byte before the program is accepted.
module prog_loader #(
  parameter int IW = 9,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  output logic          s_ready,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [IW-1:0] im_din,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          err
);

`ifdef LOADER_CSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_LEN, ST_LO, ST_HI, ST_WR, ST_DONE, ST_ERR, ST_CSUM
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_LEN, ST_LO, ST_HI, ST_WR, ST_DONE, ST_ERR
  } state_t;
`endif

  state_t state_q, state_d;

  logic          s_ready_q, s_ready_d;
  logic          im_we_q, im_we_d;
  logic          cpu_hold_q, cpu_hold_d;
  logic          load_done_q, load_done_d;
  logic          err_q, err_d;
  logic [AW-1:0] im_addr_q, im_addr_d;
  logic [IW-1:0] im_din_q, im_din_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    lo_q, lo_d;
  logic [7:0]    cnt_q, cnt_d;
`ifdef LOADER_CSUM_EN
  logic [7:0]    sum_q, sum_d;
`endif

  logic       xfer;
  logic       start_ok;
  logic       hi_bad;
  logic [7:0] cnt_inc;
  logic       last_word;

  // Handshake and bookkeeping terms shared by the next-state and datapath logic.
  // A length of 0 means 256 words; the 8-bit wrap of cnt_inc handles that for free.
  always_comb begin
    xfer      = s_valid & s_ready_q;
    start_ok  = start & ((state_q == ST_IDLE) | (state_q == ST_DONE) | (state_q == ST_ERR));
    hi_bad    = |s_data[7:1];
    cnt_inc   = cnt_q + 8'd1;
    last_word = (cnt_inc == len_q);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: bytes advance LEN/LO/HI, each completed word costs one WR cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (xfer) state_d = ST_LO;
      end
      ST_LO: begin
        if (xfer) state_d = ST_HI;
      end
      ST_HI: begin
        if (xfer) state_d = hi_bad ? ST_ERR : ST_WR;
      end
      ST_WR: begin
`ifdef LOADER_CSUM_EN
        state_d = last_word ? ST_CSUM : ST_LO;
`else
        state_d = last_word ? ST_DONE : ST_LO;
`endif
      end
`ifdef LOADER_CSUM_EN
      ST_CSUM: begin
        if (xfer) state_d = (s_data == sum_q) ? ST_DONE : ST_ERR;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    s_ready_d   = 1'b0;
    im_we_d     = 1'b0;
    cpu_hold_d  = 1'b1;
    load_done_d = 1'b0;
    err_d       = 1'b0;
    case (state_d)
      ST_LEN, ST_LO, ST_HI: s_ready_d = 1'b1;
`ifdef LOADER_CSUM_EN
      ST_CSUM:              s_ready_d = 1'b1;
`endif
      ST_WR:                im_we_d = 1'b1;
      ST_DONE: begin
        load_done_d = 1'b1;
        cpu_hold_d  = 1'b0;
      end
      ST_ERR:               err_d = 1'b1;
      default: ;
    endcase
  end

  // Datapath: latch length and low byte, assemble the word, advance address and count.
  always_comb begin
    len_d     = len_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    im_addr_d = im_addr_q;
    im_din_d  = im_din_q;
`ifdef LOADER_CSUM_EN
    sum_d     = sum_q;
`endif
    if (start_ok) begin
      im_addr_d = '0;
      cnt_d     = '0;
`ifdef LOADER_CSUM_EN
      sum_d     = '0;
`endif
    end
    case (state_q)
      ST_LEN: begin
        if (xfer) len_d = s_data;
      end
      ST_LO: begin
        if (xfer) begin
          lo_d = s_data;
`ifdef LOADER_CSUM_EN
          sum_d = sum_q + s_data;
`endif
        end
      end
      ST_HI: begin
        if (xfer && !hi_bad) begin
          im_din_d = IW'({s_data[0], lo_q});
`ifdef LOADER_CSUM_EN
          sum_d = sum_q + s_data;
`endif
        end
      end
      ST_WR: begin
        im_addr_d = im_addr_q + AW'(1);
        cnt_d     = cnt_inc;
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_ready_q   <= 1'b0;
      im_we_q     <= 1'b0;
      cpu_hold_q  <= 1'b1;
      load_done_q <= 1'b0;
      err_q       <= 1'b0;
      im_addr_q   <= '0;
      im_din_q    <= '0;
      len_q       <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
`ifdef LOADER_CSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      s_ready_q   <= s_ready_d;
      im_we_q     <= im_we_d;
      cpu_hold_q  <= cpu_hold_d;
      load_done_q <= load_done_d;
      err_q       <= err_d;
      im_addr_q   <= im_addr_d;
      im_din_q    <= im_din_d;
      len_q       <= len_d;
      lo_q        <= lo_d;
      cnt_q       <= cnt_d;
`ifdef LOADER_CSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign s_ready   = s_ready_q;
  assign im_we     = im_we_q;
  assign im_addr   = im_addr_q;
  assign im_din    = im_din_q;
  assign cpu_hold  = cpu_hold_q;
  assign load_done = load_done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader. Loads are described as byte streams; a stream
// parser inside the bench derives the expected writes and final status.
// When LOADER_CSUM_EN is defined the bench appends the checksum byte.
module tb_prog_loader;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    logic [0:7][7:0] b;
    int              nb;
    int              exp_writes;
    logic            exp_err;
    logic [8:0]      last_din;
    logic [7:0]      exp_addr;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_ready;
  logic       im_we;
  logic [7:0] im_addr;
  logic [8:0] im_din;
  logic       cpu_hold;
  logic       load_done;
  logic       err;

  int checks = 0;
  int failures = 0;

  logic [16:0] wlog[$];
  logic [16:0] exp_wr[$];
  logic        exp_err;
  int          exp_nsend;
  logic [7:0]  exp_csum;
  logic        loading = 1'b0;
  int          ready_low = 0;
  int          we_ready = 0;

  prog_loader #(.IW(9), .AW(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .im_we(im_we), .im_addr(im_addr), .im_din(im_din),
    .cpu_hold(cpu_hold), .load_done(load_done), .err(err)
  );

  always #5 clk = ~clk;

  // Record every write and watch handshake behaviour away from the rising edge.
  always @(negedge clk) begin
    if (im_we) wlog.push_back({im_addr, im_din});
    if (im_we && s_ready) we_ready++;
    if (loading && !s_ready && !load_done && !err) ready_low++;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: got timeout expected handshake", name);
  endtask

  // Stream parser: words are (lo, hi) pairs; a high byte above 1 ends the load in error.
  task automatic build_expected(input byte_q_t strm);
    int n;
    logic [7:0] lo, hi;
    exp_wr.delete();
    exp_err = 1'b0;
    exp_csum = 8'h00;
    n = (strm[0] == 8'h00) ? 256 : int'(strm[0]);
    exp_nsend = 1;
    for (int i = 0; i < n; i++) begin
      lo = strm[1 + 2*i];
      hi = strm[2 + 2*i];
      exp_nsend += 2;
      exp_csum = exp_csum + lo + hi;
      if (hi > 8'd1) begin
        exp_err = 1'b1;
        return;
      end
      exp_wr.push_back({8'(i), hi[0], lo});
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    s_data = b;
    s_valid = 1'b1;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      if (s_ready) ok = 1'b1;
    end
    if (!ok) timeout_fail("send_byte");
    else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_range(input byte_q_t strm, input int from, input int upto, input bit gaps);
    bit ok;
    for (int i = from; i < upto; i++) begin
      send_byte(strm[i], ok);
      if (!ok) return;
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic send_csum(input bit bad);
`ifdef LOADER_CSUM_EN
    bit ok;
    if (!exp_err) send_byte(exp_csum + {7'd0, bad}, ok);
`else
    if (bad) $display("[TB] checksum corruption requested without checksum stage");
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic begin_load();
    wlog.delete();
    ready_low = 0;
    we_ready = 0;
    s_valid = 1'b0;
    pulse_start();
    loading = 1'b1;
    checkOutput("entry_err", err, 0);
    checkOutput("entry_done", load_done, 0);
    checkOutput("entry_hold", cpu_hold, 1);
    checkOutput("entry_ready", s_ready, 1);
  endtask

  task automatic finish_load(input bit bad);
    bit got;
    bit e;
    s_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (load_done || err) got = 1'b1;
    end
    if (!got) timeout_fail("terminal_state");
    #1;
    loading = 1'b0;
    e = exp_err | bad;
    checkOutput("err", err, e);
    checkOutput("load_done", load_done, !e);
    checkOutput("cpu_hold", cpu_hold, e);
    checkOutput("s_ready_end", s_ready, 0);
    checkOutput("write_count", wlog.size(), exp_wr.size());
    for (int i = 0; i < wlog.size() && i < exp_wr.size(); i++)
      checkOutput($sformatf("write[%0d]", i), wlog[i], exp_wr[i]);
    checkOutput("im_addr_end", im_addr, exp_wr.size() % 256);
    checkOutput("ready_low_cycles", ready_low, exp_wr.size());
    checkOutput("we_with_ready", we_ready, 0);
  endtask

  task automatic applyStimulus(input byte_q_t strm, input bit bad, input bit gaps);
    build_expected(strm);
    begin_load();
    send_range(strm, 0, exp_nsend, gaps);
    send_csum(bad);
    finish_load(bad);
  endtask

  vec_t    vecs[6];
  byte_q_t q;

  initial begin
    // Table of directed loads; entry 1 is an error that entry 2 must recover from.
    vecs[0] = '{b: {8'h02, 8'h34, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00}, nb: 5, exp_writes: 2, exp_err: 0, last_din: 9'h0FF, exp_addr: 8'd2};
    vecs[1] = '{b: {8'h01, 8'h10, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, nb: 3, exp_writes: 0, exp_err: 1, last_din: 9'h000, exp_addr: 8'd0};
    vecs[2] = '{b: {8'h03, 8'hAA, 8'h01, 8'h55, 8'h00, 8'h0F, 8'h01, 8'h00}, nb: 7, exp_writes: 3, exp_err: 0, last_din: 9'h10F, exp_addr: 8'd3};
    vecs[3] = '{b: {8'h02, 8'h11, 8'h00, 8'h22, 8'h80, 8'h00, 8'h00, 8'h00}, nb: 5, exp_writes: 1, exp_err: 1, last_din: 9'h011, exp_addr: 8'd1};
    vecs[4] = '{b: {8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, nb: 3, exp_writes: 1, exp_err: 0, last_din: 9'h000, exp_addr: 8'd1};
    vecs[5] = '{b: {8'h01, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, nb: 3, exp_writes: 1, exp_err: 0, last_din: 9'h1FF, exp_addr: 8'd1};

    // Reset values while held, then quiet IDLE after release.
    repeat (3) @(negedge clk);
    checkOutput("rst_s_ready", s_ready, 0);
    checkOutput("rst_im_we", im_we, 0);
    checkOutput("rst_im_addr", im_addr, 0);
    checkOutput("rst_im_din", im_din, 0);
    checkOutput("rst_cpu_hold", cpu_hold, 1);
    checkOutput("rst_load_done", load_done, 0);
    checkOutput("rst_err", err, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("idle_writes", wlog.size(), 0);
    checkOutput("idle_s_ready", s_ready, 0);
    checkOutput("idle_cpu_hold", cpu_hold, 1);
    @(posedge clk);
    #1;

    // Directed table with continuous valid (back-pressure only from WR).
    for (int v = 0; v < 6; v++) begin
      q.delete();
      for (int i = 0; i < vecs[v].nb; i++) q.push_back(vecs[v].b[i]);
      applyStimulus(q, 1'b0, 1'b0);
      checkOutput($sformatf("vec%0d_err", v), err, vecs[v].exp_err);
      checkOutput($sformatf("vec%0d_writes", v), wlog.size(), vecs[v].exp_writes);
      checkOutput($sformatf("vec%0d_addr", v), im_addr, vecs[v].exp_addr);
      if (wlog.size() > 0)
        checkOutput($sformatf("vec%0d_last_din", v), wlog[wlog.size()-1][8:0], vecs[v].last_din);
    end

    // Start pulse in the middle of a load must be ignored.
    q = '{8'h02, 8'h34, 8'h01, 8'hFF, 8'h00};
    build_expected(q);
    begin_load();
    send_range(q, 0, 2, 1'b0);
    s_valid = 1'b0;
    pulse_start();
    send_range(q, 2, 5, 1'b0);
    send_csum(1'b0);
    finish_load(1'b0);

    // Start and a valid byte together in DONE: start wins, byte is kept for LEN.
    q = '{8'h01, 8'h5A, 8'h01};
    build_expected(q);
    wlog.delete();
    ready_low = 0;
    we_ready = 0;
    s_data = 8'h01;
    s_valid = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    loading = 1'b1;
    checkOutput("start_wins_ready", s_ready, 1);
    checkOutput("start_wins_done", load_done, 0);
    send_range(q, 0, 3, 1'b0);
    send_csum(1'b0);
    finish_load(1'b0);
    checkOutput("start_wins_din", wlog.size() > 0 ? wlog[0] : 17'h1FFFF, {8'h00, 9'h15A});

`ifdef LOADER_CSUM_EN
    // Checksum accepted, then rejected with the word still written.
    q = '{8'h01, 8'h34, 8'h01};
    applyStimulus(q, 1'b0, 1'b0);
    applyStimulus(q, 1'b1, 1'b0);
    checkOutput("csum_bad_word0", wlog.size() > 0 ? wlog[0] : 17'h1FFFF, {8'h00, 9'h134});
`endif

    // Full depth: 256 words, address wraps back to 0.
    q.delete();
    q.push_back(8'h00);
    for (int i = 0; i < 256; i++) begin
      q.push_back(8'($urandom_range(0, 255)));
      q.push_back(8'($urandom_range(0, 1)));
    end
    applyStimulus(q, 1'b0, 1'b0);
    checkOutput("full_last_addr", wlog.size() == 256 ? wlog[255][16:9] : 8'h00, 8'hFF);
    checkOutput("full_wrap_addr", im_addr, 0);

    // Reset after the tenth word of a second full-depth load.
    build_expected(q);
    begin_load();
    send_range(q, 0, 21, 1'b0);
    s_valid = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        @(negedge clk);
        if (im_we && im_addr == 8'd9) seen = 1'b1;
      end
      if (!seen) timeout_fail("tenth_write");
    end
    reset = 1'b0;
    loading = 1'b0;
    #1;
    checkOutput("midrst_cpu_hold", cpu_hold, 1);
    checkOutput("midrst_s_ready", s_ready, 0);
    checkOutput("midrst_im_we", im_we, 0);
    checkOutput("midrst_im_addr", im_addr, 0);
    checkOutput("midrst_load_done", load_done, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("midrst_writes", wlog.size(), 10);
    checkOutput("midrst_idle_ready", s_ready, 0);
    checkOutput("midrst_idle_hold", cpu_hold, 1);
    @(posedge clk);
    #1;

    // Randomised loads with idle gaps and occasional malformed high bytes.
    for (int t = 0; t < 25; t++) begin
      int n;
      int bad_at;
      n = $urandom_range(1, 8);
      bad_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      q.delete();
      q.push_back(8'(n));
      for (int i = 0; i < n; i++) begin
        q.push_back(8'($urandom_range(0, 255)));
        if (i == bad_at) q.push_back(8'($urandom_range(2, 255)));
        else q.push_back(8'($urandom_range(0, 1)));
      end
      applyStimulus(q, 1'b0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction-memory interface. The CPU only ever reads instruction memory.
- Accepts a byte stream from a host over a valid/ready handshake and assembles 9-bit instructions from byte pairs.
- Writes those instructions sequentially into instruction memory through a write port.
- Holds the CPU in reset (cpu_hold) until a complete, error-free program has been loaded.

Parameters:
- IW, 9, instruction width in bits (fixed by the ISA; only 9 is supported).
- AW, 8, instruction memory address width; the PC is 8 bits.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- s_valid  in  1  host byte valid.
- s_data  in  8  host byte.
- s_ready  out  1  loader can accept a byte; a byte transfers when s_valid && s_ready on a clock edge.
- im_we  out  1  instruction memory write enable, one-cycle pulse per word.
- im_addr  out  AW  instruction memory write address.
- im_din  out  IW  instruction word to write.
- cpu_hold  out  1  1 = keep the CPU in reset.
- load_done  out  1  program loaded successfully.
- err  out  1  malformed stream detected.

Behaviour:
- Reset values (async, while reset==0):
  - state=IDLE, s_ready=0, im_we=0, im_addr=0, im_din=0.
  - cpu_hold=1, load_done=0, err=0, word counter=0.
- All outputs are registered.
- Stream format:
  - First byte is the word count N. A value of 0 means 256 words.
  - Then N byte pairs: low byte first, giving inst[7:0]; high byte second, whose bit0 is inst[8] and whose bits[7:1] must be 0.
- States:
  - IDLE: s_ready=0. start -> LEN; on entry clear load_done and err, set cpu_hold=1, im_addr=0, counter=0.
  - LEN: s_ready=1. On transfer, latch N -> LO.
  - LO: s_ready=1. On transfer, latch low byte -> HI.
  - HI: s_ready=1. On transfer:
    - if s_data[7:1]!=0 -> ERR, with no write;
    - else load im_din={s_data[0],lo}, pulse im_we next cycle -> WR.
  - WR: s_ready=0, im_we=1 for exactly this cycle at the current im_addr. At end of cycle, im_addr increments (mod 2^AW) and the counter increments.
    - If counter+1==N (256 when N==0) -> DONE, or -> CSUM when LOADER_CSUM_EN is defined.
    - Else -> LO.
  - DONE: load_done=1, cpu_hold=0, s_ready=0. start -> LEN with the same entry actions as from IDLE.
  - ERR: err=1, cpu_hold=1, load_done=0, s_ready=0. start -> LEN with the same entry actions.
- Latency: im_we asserts on the cycle after the high-byte transfer.
- Throughput: one word every 3 cycles at best, because of the WR bubble.
- Back-pressure: s_ready=0 in WR. The host holds s_valid/s_data, and no byte is lost or duplicated.
- start while in LEN/LO/HI/WR/CSUM is ignored.
- s_valid while s_ready=0 is ignored.
- Address wrap: after the 256th write im_addr returns to 0; no extra write occurs.
- A start and a byte transfer in the same cycle from DONE: start wins. The byte is not consumed because s_ready=0.
- Reset asserted mid-load: immediately returns to the reset values.
  - Memory contents already written are left as-is.
  - cpu_hold stays 1.

Optional Feature:
- Macro: LOADER_CSUM_EN.
- Defined:
  - After the last word, state CSUM (s_ready=1) accepts one checksum byte.
  - The checksum is the mod-256 sum of every stream byte after the length byte (all lo and hi bytes).
  - The running sum clears on entry to LEN.
  - Match -> DONE; mismatch -> ERR. Words already written remain.
- Undefined: no CSUM state and no sum register; WR goes straight to DONE after the last word.

Test Plan:
- Reset: hold reset=0 -> s_ready=0, im_we=0, im_addr=0, cpu_hold=1, load_done=0, err=0; release -> state stays IDLE with no writes.
- Basic load:
  - Stimulus: start, then bytes 0x02, 0x34, 0x01, 0xFF, 0x00.
  - Required: im_we pulses twice — addr 0x00 din 0x134, then addr 0x01 din 0x0FF.
  - Then load_done=1 and cpu_hold=0, with exactly 2 write pulses.
- Back-pressure: host holds s_valid=1 continuously → s_ready drops for exactly the WR cycle after each high byte; with N=3, each byte is consumed exactly once and exactly 3 writes occur.
- Error: start, N=1, lo=0x10, hi=0x02 → err=1, no im_we pulse, cpu_hold=1; a following start clears err and reloads correctly.
- Full depth: N=0x00 with 256 word pairs → last write at addr 0xFF, im_addr wraps to 0x00, load_done=1; reset asserted after word 10 of a second load → cpu_hold=1, state returns to IDLE.
- Checksum (LOADER_CSUM_EN):
  - Stimulus: N=1, bytes 0x34, 0x01, checksum 0x35.
  - Required: DONE.
  - Same stimulus with checksum 0x36: ERR, with err=1 and the word at addr 0 still written.
